hb_decim: RTL and testbench

Half-band decimate-by-2 FIR stage placed directly after the ISOP compensator in the bit-stream decimation chain (CIC ÷128 → ISOP → this block). It consumes the compensator's 47-bit signed output at its ND rate (4 kHz at fs = 512 kHz) and delivers one filtered 47-bit sample for every two inputs. It uses a single time-shared multiplier, since there are 128 system clocks between input samples.

---
 rtl/hb_decim.sv | 144 ++++++++++++++
 tb/tb_hb_decim.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_decim.sv
// rtl/hb_decim.sv - half-band decimate-by-2 FIR stage with one time-shared multiplier
module hb_decim #(
  parameter int DW = 47,
  parameter int CW = 11,
  parameter int SH = 10,
  parameter logic signed [CW-1:0] C0 = CW'(12),
  parameter logic signed [CW-1:0] C2 = CW'(-61),
  parameter logic signed [CW-1:0] C4 = CW'(305),
  parameter logic signed [CW-1:0] C5 = CW'(512)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ND,
  input  logic signed [DW-1:0] HbIn,
  output logic signed [DW-1:0] HbOut,
  output logic                 HbND,
  output logic                 HbSat,
  output logic                 HbOvr
);

  // pair sums need one extra bit; product and accumulator keep full precision
  localparam int SW = DW + 1;
  localparam int PW = SW + CW;
  localparam int AW = PW + 3;
  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (SH - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PRE, MAC, OUT} state_t;

  state_t                state, state_nxt;
  logic signed [DW-1:0]  x [0:10];
  logic                  p;
  logic                  start;
  logic [1:0]            k;
  logic signed [SW-1:0]  s [0:3];
  logic signed [SW-1:0]  s_sel;
  logic signed [CW-1:0]  coef_sel;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  rnd;
  logic signed [AW-1:0]  r;
  logic                  over;
  logic                  under;
  logic signed [DW-1:0]  sat_val;

  // a computation starts on every second input sample
  assign start = ND && p;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: PRE, four MAC beats, one OUT beat
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRE;
      PRE:     state_nxt = MAC;
      MAC:     if (k == 2'd3) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // delay line and decimation phase run on every input strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 11; i++) x[i] <= '0;
      p <= 1'b0;
    end else if (ND) begin
      x[0] <= HbIn;
      for (int i = 1; i < 11; i++) x[i] <= x[i-1];
      p <= ~p;
    end
  end

  // select the symmetric pair sum and its coefficient for the current beat
  always_comb begin
    s_sel    = s[k];
    coef_sel = C5;
    case (k)
      2'd0:    coef_sel = C0;
      2'd1:    coef_sel = C2;
      2'd2:    coef_sel = C4;
      default: coef_sel = C5;
    endcase
  end

  assign prod = PW'(s_sel) * PW'(coef_sel);

  // round half up, arithmetic shift back to sample scale, then clip
  assign rnd   = acc + HALF;
  assign r     = rnd >>> SH;
  assign over  = r > MAXV;
  assign under = r < MINV;

  // clipped output value
  always_comb begin
    sat_val = r[DW-1:0];
    if (over)       sat_val = MAXV[DW-1:0];
    else if (under) sat_val = MINV[DW-1:0];
  end

  // datapath: snapshot pair sums, accumulate, publish result, flag overruns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) s[i] <= '0;
      acc   <= '0;
      k     <= '0;
      HbOut <= '0;
      HbND  <= 1'b0;
      HbSat <= 1'b0;
      HbOvr <= 1'b0;
    end else begin
      HbND  <= 1'b0;
      HbSat <= 1'b0;
      if (start && state != IDLE) HbOvr <= 1'b1;
      case (state)
        PRE: begin
          s[0] <= SW'(x[0]) + SW'(x[10]);
          s[1] <= SW'(x[2]) + SW'(x[8]);
          s[2] <= SW'(x[4]) + SW'(x[6]);
          s[3] <= SW'(x[5]);
          acc  <= '0;
          k    <= '0;
        end
        MAC: begin
          acc <= acc + AW'(prod);
          k   <= k + 2'd1;
        end
        OUT: begin
          HbOut <= sat_val;
          HbND  <= 1'b1;
          HbSat <= over || under;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hb_decim.sv
// tb/tb_hb_decim.sv - self-checking bench for hb_decim
module tb_hb_decim;

  localparam int DW = 47;
  localparam longint MAXV = (longint'(1) <<< 46) - 1;
  localparam longint MINV = -(longint'(1) <<< 46);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 ND = 1'b0;
  logic signed [DW-1:0] HbIn = '0;
  logic signed [DW-1:0] HbOut;
  logic                 HbND;
  logic                 HbSat;
  logic                 HbOvr;

  hb_decim dut (
    .clk   (clk),
    .rst   (rst),
    .ND    (ND),
    .HbIn  (HbIn),
    .HbOut (HbOut),
    .HbND  (HbND),
    .HbSat (HbSat),
    .HbOvr (HbOvr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     due;
    longint val;
    bit     sat;
  } exp_t;

  typedef struct {
    logic [10:0] sel_a;
    longint      val_a;
    logic [10:0] sel_b;
    longint      val_b;
    longint      exp_out;
    bit          exp_sat;
  } vec_t;

  longint samples[$];
  exp_t   expq[$];
  longint hb_log[$];
  int     last_start;
  int     ovr_edge;
  longint last_out;
  int     hbnd_count;
  int     checks = 0;
  int     errors = 0;
  vec_t   vecs[14];
  longint exp_even[7];
  longint exp_odd[7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint coef(input int j);
    case (j)
      0, 10:   return 12;
      2, 8:    return -61;
      4, 6:    return 305;
      5:       return 512;
      default: return 0;
    endcase
  endfunction

  // filter output over everything received since reset, zeros before the first sample
  task automatic ref_out(output longint r, output bit sat);
    longint acc;
    int idx;
    acc = 0;
    for (int j = 0; j < 11; j++) begin
      idx = samples.size() - 1 - j;
      if (idx >= 0) acc += coef(j) * samples[idx];
    end
    r = (acc + 512) >>> 10;
    sat = 1'b0;
    if (r > MAXV) begin r = MAXV; sat = 1'b1; end
    else if (r < MINV) begin r = MINV; sat = 1'b1; end
  endtask

  // every even-numbered sample is a start; the engine is busy for edges n..n+6
  task automatic model_push(input longint v, input int edge_n);
    longint r;
    bit sat;
    samples.push_back(v);
    if (samples.size() % 2 == 0) begin
      if (edge_n - last_start >= 7) begin
        last_start = edge_n;
        ref_out(r, sat);
        expq.push_back('{edge_n + 6, r, sat});
      end else if (ovr_edge > edge_n) begin
        ovr_edge = edge_n;
      end
    end
  endtask

  task automatic drive_cycle(input bit nd_v, input longint v);
    @(negedge clk);
    ND   = nd_v;
    HbIn = v[DW-1:0];
    if (nd_v) model_push(v, cyc + 1);
  endtask

  task automatic nd(input longint v);
    drive_cycle(1'b1, v);
    drive_cycle(1'b0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst  = 1'b0;
    ND   = 1'b0;
    HbIn = '0;
    samples.delete();
    expq.delete();
    last_start = -1000;
    ovr_edge   = 2147483647;
    last_out   = 0;
    #1;
    check("rst_hbout", HbOut, 0);
    check("rst_hbnd", HbND, 0);
    check("rst_hbsat", HbSat, 0);
    check("rst_hbovr", HbOvr, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic longint rnd47();
    logic [63:0] w;
    longint t;
    w = {$urandom(), $urandom()};
    t = longint'(w);
    t = t <<< 17;
    return t >>> 17;
  endfunction

  // continuous comparison of strobe timing, values, hold and overrun flag
  always @(negedge clk) begin
    if (rst) begin
      if (HbND) begin
        hbnd_count++;
        hb_log.push_back(longint'(HbOut));
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
        check("hbnd_strobe", HbND, 1);
        check("hbout", HbOut, expq[0].val);
        check("hbsat", HbSat, expq[0].sat);
        last_out = expq[0].val;
        void'(expq.pop_front());
      end else begin
        check("hbnd_idle", HbND, 0);
        check("hbsat_idle", HbSat, 0);
        check("hbout_hold", HbOut, last_out);
      end
      check("hbovr", HbOvr, (cyc >= ovr_edge) ? 1 : 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    longint tap;
    bit     seen;
    longint v;

    vecs[0]  = '{11'h7FF, 1000,  11'h000, 0,    1000,  1'b0};
    vecs[1]  = '{11'h7FF, -1000, 11'h000, 0,    -1000, 1'b0};
    vecs[2]  = '{11'h001, 1024,  11'h000, 0,    12,    1'b0};
    vecs[3]  = '{11'h004, 1024,  11'h000, 0,    -61,   1'b0};
    vecs[4]  = '{11'h010, 1024,  11'h000, 0,    305,   1'b0};
    vecs[5]  = '{11'h020, 1024,  11'h000, 0,    512,   1'b0};
    vecs[6]  = '{11'h002, 1024,  11'h000, 0,    0,     1'b0};
    vecs[7]  = '{11'h400, 1024,  11'h000, 0,    12,    1'b0};
    vecs[8]  = '{11'h471, MAXV,  11'h104, MINV, MAXV,  1'b1};
    vecs[9]  = '{11'h471, MINV,  11'h104, MAXV, MINV,  1'b1};
    vecs[10] = '{11'h020, 1,     11'h000, 0,    1,     1'b0};
    vecs[11] = '{11'h020, -1,    11'h000, 0,    0,     1'b0};
    vecs[12] = '{11'h010, 2,     11'h000, 0,    1,     1'b0};
    vecs[13] = '{11'h001, -43,   11'h000, 0,    -1,    1'b0};
    exp_even = '{12, -61, 305, 305, -61, 12, 0};
    exp_odd  = '{0, 0, 512, 0, 0, 0, 0};

    // table vectors: load the line oldest-first so the 12th sample starts a computation
    for (int i = 0; i < 14; i++) begin
      do_reset();
      nd(0);
      for (int j = 10; j >= 0; j--) begin
        tap = vecs[i].sel_a[j] ? vecs[i].val_a : (vecs[i].sel_b[j] ? vecs[i].val_b : 0);
        idle(6);
        nd(tap);
      end
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        drive_cycle(1'b0, 0);
        if (HbND) begin
          seen = 1'b1;
          check($sformatf("vec%0d_out", i), HbOut, vecs[i].exp_out);
          check($sformatf("vec%0d_sat", i), HbSat, vecs[i].exp_sat);
        end
      end
      check($sformatf("vec%0d_seen", i), seen, 1);
    end

    // even impulse response
    do_reset();
    hb_log.delete();
    for (int n = 1; n <= 14; n++) begin
      idle(6);
      nd(n == 2 ? 1024 : 0);
    end
    idle(10);
    check("even_count", hb_log.size(), 7);
    for (int m = 0; m < 7; m++)
      check($sformatf("even_%0d", m), (m < hb_log.size()) ? hb_log[m] : -1, exp_even[m]);

    // odd impulse response
    do_reset();
    hb_log.delete();
    for (int n = 1; n <= 14; n++) begin
      idle(6);
      nd(n == 1 ? 1024 : 0);
    end
    idle(10);
    check("odd_count", hb_log.size(), 7);
    for (int m = 0; m < 7; m++)
      check($sformatf("odd_%0d", m), (m < hb_log.size()) ? hb_log[m] : -1, exp_odd[m]);

    // overrun: strobes at t, t+1, t+3 with t a start
    do_reset();
    nd(5);
    idle(6);
    hbnd_count = 0;
    drive_cycle(1'b1, 100);
    drive_cycle(1'b1, 200);
    drive_cycle(1'b0, 0);
    drive_cycle(1'b1, 300);
    drive_cycle(1'b0, 0);
    idle(15);
    check("ovr_flag", HbOvr, 1);
    check("ovr_one_hbnd", hbnd_count, 1);
    nd(1);
    idle(8);
    nd(2);
    idle(20);
    check("ovr_sticky", HbOvr, 1);

    // reset in the middle of a computation aborts it
    do_reset();
    nd(1000);
    idle(6);
    drive_cycle(1'b1, 1000);
    drive_cycle(1'b0, 0);
    drive_cycle(1'b0, 0);
    do_reset();
    hbnd_count = 0;
    idle(20);
    check("abort_no_hbnd", hbnd_count, 0);
    nd(7);
    idle(6);
    nd(9);
    idle(10);
    check("post_rst_one_hbnd", hbnd_count, 1);

    // randomized traffic including back-to-back strobes and extreme values
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      idle($urandom_range(0, 10));
      case ($urandom_range(0, 3))
        0:       v = rnd47();
        1:       v = ($urandom_range(0, 1) != 0) ? MAXV : MINV;
        default: v = longint'($urandom_range(0, 4000)) - 2000;
      endcase
      nd(v);
    end
    idle(12);
    check("rand_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
